// File: rtl/siso_iter_sched_if.sv
// Bus between the turbo iteration scheduler and its neighbours: the request
// port, the SISO start handshake, the sample-buffer read port and the status strobes.
interface siso_iter_sched_if #(
  parameter int ITER_W = 4,
  parameter int ADDR_W = 13
);
  // Handshake semantics: a request is accepted on a rising edge where
  // valid_blklen=1 and ready=1; valid_blklen is a one-cycle strobe and is
  // ignored while ready=0. siso_start is a one-cycle pulse issued only on an
  // edge where siso_ready=1. ext_valid is a per-cycle strobe with no back-pressure.
  logic [15:0]       blklen;
  logic [ITER_W-1:0] n_iter;
  logic              valid_blklen;
  logic              abort;
  logic              ready;
  logic              siso_ready;
  logic              siso_start;
  logic [15:0]       siso_blklen;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_interleaved;
  logic              ext_valid;
  logic              half;
  logic [ITER_W-1:0] iter;
  logic              done;
  logic              err;

  modport slave (
    input  blklen, n_iter, valid_blklen, abort, siso_ready, ext_valid,
    output ready, siso_start, siso_blklen, rd_en, rd_addr, rd_interleaved,
           half, iter, done, err
  );

  modport master (
    output blklen, n_iter, valid_blklen, abort, siso_ready, ext_valid,
    input  ready, siso_start, siso_blklen, rd_en, rd_addr, rd_interleaved,
           half, iter, done, err
  );
endinterface

// File: rtl/siso_iter_sched.sv
// Turbo SISO iteration scheduler: runs 2*n_eff half-iterations (natural then
// interleaved order), feeding K+3 sample addresses and counting K extrinsics each.
module siso_iter_sched #(
  parameter int MAX_ITER = 8,
  parameter int ITER_W   = 4,
  parameter int ADDR_W   = 13
) (
  input  logic             clk,
  input  logic             rst,
  siso_iter_sched_if.slave bus,
  output logic [2:0]       dbg_state
);
  typedef enum logic [2:0] {IDLE, CHECK, START, FEED, WAIT_EXT, NEXT, DONE} state_t;

  localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  state_t            state_q, state_d;
  logic [15:0]       k_q, k_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ITER_W-1:0] n_eff_q, n_eff_d;
  logic [ITER_W-1:0] iter_q, iter_d, iter_inc;
  logic [ADDR_W-1:0] addr_q, addr_d, last_addr;
  logic              half_q, half_d;
  logic              ready_q, ready_d;
  logic              start_q, start_d;
  logic              rd_en_q, rd_en_d;
  logic              inter_q, inter_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // LTE code-block sizes: four ranges with a coarser step in each.
  function automatic logic lte_len(input logic [15:0] k);
    lte_len = ((k >= 16'd40)   && (k <= 16'd512)  && (k[2:0] == 3'd0)) ||
              ((k >= 16'd528)  && (k <= 16'd1024) && (k[3:0] == 4'd0)) ||
              ((k >= 16'd1056) && (k <= 16'd2048) && (k[4:0] == 5'd0)) ||
              ((k >= 16'd2112) && (k <= 16'd6144) && (k[5:0] == 6'd0));
  endfunction

  function automatic logic [ITER_W-1:0] clamp_iter(input logic [ITER_W-1:0] n);
    if (n == '0)
      clamp_iter = ITER_ONE;
    else if (n > ITER_MAX)
      clamp_iter = ITER_MAX;
    else
      clamp_iter = n;
  endfunction

  assign last_addr = ADDR_W'(k_q + 16'd2);
  assign iter_inc  = iter_q + ITER_ONE;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    n_eff_d = n_eff_q;
    iter_d  = iter_q;
    addr_d  = addr_q;
    half_d  = half_q;
    ready_d = 1'b0;
    start_d = 1'b0;
    rd_en_d = 1'b0;
    inter_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    // Extrinsics count from the siso_start cycle (first FEED cycle) and saturate at K.
    if ((state_q == FEED || state_q == WAIT_EXT) && bus.ext_valid && (cnt_q < k_q))
      cnt_d = cnt_q + 16'd1;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.valid_blklen) begin
          k_d     = bus.blklen;
          n_eff_d = clamp_iter(bus.n_iter);
          ready_d = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (lte_len(k_q)) begin
          half_d  = 1'b0;
          iter_d  = '0;
          state_d = START;
        end else begin
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      START: begin
        if (bus.siso_ready) begin
          start_d = 1'b1;
          rd_en_d = 1'b1;
          inter_d = half_q;
          addr_d  = '0;
          cnt_d   = '0;
          state_d = FEED;
        end
      end
      FEED: begin
        if (addr_q == last_addr) begin
          state_d = WAIT_EXT;
        end else begin
          rd_en_d = 1'b1;
          inter_d = half_q;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      WAIT_EXT: begin
        if (cnt_q == k_q)
          state_d = NEXT;
      end
      NEXT: begin
        if (!half_q) begin
          half_d  = 1'b1;
          state_d = START;
        end else begin
          half_d = 1'b0;
          iter_d = iter_inc;
          if (iter_inc == n_eff_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = START;
          end
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything and lands in the reset state without a status pulse.
    if (bus.abort) begin
      state_d = IDLE;
      k_d     = '0;
      cnt_d   = '0;
      n_eff_d = '0;
      iter_d  = '0;
      addr_d  = '0;
      half_d  = 1'b0;
      ready_d = 1'b1;
      start_d = 1'b0;
      rd_en_d = 1'b0;
      inter_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      n_eff_q <= '0;
      iter_q  <= '0;
      addr_q  <= '0;
      half_q  <= 1'b0;
      ready_q <= 1'b1;
      start_q <= 1'b0;
      rd_en_q <= 1'b0;
      inter_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      n_eff_q <= n_eff_d;
      iter_q  <= iter_d;
      addr_q  <= addr_d;
      half_q  <= half_d;
      ready_q <= ready_d;
      start_q <= start_d;
      rd_en_q <= rd_en_d;
      inter_q <= inter_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready          = ready_q;
  assign bus.siso_start     = start_q;
  assign bus.siso_blklen    = k_q;
  assign bus.rd_en          = rd_en_q;
  assign bus.rd_addr        = addr_q;
  assign bus.rd_interleaved = inter_q;
  assign bus.half           = half_q;
  assign bus.iter           = iter_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign dbg_state          = state_q;
endmodule

// File: doc/siso_iter_sched.md
# siso_iter_sched

Iteration scheduler for the turbo SISO decoder datapath. It takes a code-block length and an iteration count. It then runs the shared `top` SISO instance through 2 × n_iter half-iterations:
- Even half-iterations use natural order.
- Odd half-iterations use interleaved order.

For each half-iteration it issues the start handshake, generates sample read addresses and counts returned extrinsic values. It sits between the block-input buffer and the SISO core.

## Interface
Parameters:
- `MAX_ITER`, 8: upper clamp on requested full iterations.
- `ITER_W`, 4: width of iteration fields.
- `ADDR_W`, 13: width of read address; must hold 6146.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `blklen`  in  16  requested code-block length K, unsigned.
- `n_iter`  in  ITER_W  requested full iterations; sampled together with `blklen`.
- `valid_blklen`  in  1  single-cycle request strobe; honoured only in IDLE.
- `abort`  in  1  synchronous abort; takes priority over every other input.
- `ready`  out  1  high while in IDLE.
- `siso_ready`  in  1  SISO core can accept a new half-iteration.
- `siso_start`  out  1  one-cycle start pulse to the SISO core.
- `siso_blklen`  out  16  latched K; held stable from CHECK until IDLE.
- `rd_en`  out  1  sample-buffer read enable.
- `rd_addr`  out  ADDR_W  sample-buffer read address.
- `rd_interleaved`  out  1  0 selects natural order, 1 selects the interleaved buffer view.
- `ext_valid`  in  1  extrinsic-valid strobe from the SISO core.
- `half`  out  1  current half-iteration index: 0 or 1.
- `iter`  out  ITER_W  number of completed full iterations.
- `done`  out  1  one-cycle pulse when all iterations are complete.
- `err`  out  1  one-cycle pulse when K is rejected.

## Operation
- FSM states: IDLE, CHECK, START, FEED, WAIT_EXT, NEXT, DONE.
- **IDLE:** `ready`=1. On `valid_blklen`:
  - latch K and n_iter;
  - set n_eff = max(1, min(n_iter, MAX_ITER));
  - go to CHECK.
- **CHECK** takes 1 cycle. K is legal if it is an LTE length: 40..512 step 8, 528..1024 step 16, 1056..2048 step 32, 2112..6144 step 64.
  - Illegal K: `err` pulse, go to IDLE.
  - Legal K: clear `half` and `iter`, go to START.
- **START:** wait for `siso_ready`=1. Then pulse `siso_start`, reset `rd_addr` to 0 and the extrinsic counter to 0, and go to FEED.
- **FEED:**
  - `rd_en`=1 for exactly K+3 cycles, covering K systematic samples plus 3 tail samples.
  - `rd_addr` runs 0..K+2, incrementing by 1 per cycle.
  - `rd_interleaved`=`half`.
  - After the last address, go to WAIT_EXT.
- **Extrinsic counter:** counts `ext_valid` from the `siso_start` cycle onward, in both FEED and WAIT_EXT.
  - Saturates at K; strobes beyond K are ignored.
- **WAIT_EXT:** when the counter equals K, go to NEXT. This happens immediately if K was already reached during FEED.
- **NEXT** takes 1 cycle:
  - If `half`=0: set `half` to 1, go to START.
  - Otherwise: `half`→0, `iter`→`iter`+1. Go to DONE if the new `iter` equals n_eff, else go to START.
- **DONE:** `done` pulse, go to IDLE. `iter` holds n_eff until the next accepted request.
- **Requests outside IDLE:** `valid_blklen` is ignored.
- **abort:** from any state, all outputs return to reset values next cycle and the FSM goes to IDLE. No `done` or `err` pulse is produced.
- **rst low:** immediate return to reset state, also mid-operation.

## Timing
- Reset values: `ready`=1; all other outputs 0, including `siso_blklen`, `rd_addr` and `iter`.
- All outputs are registered.
- Request path:
  - `valid_blklen` sampled at edge e → CHECK after e.
  - START after e+1.
  - If `siso_ready`=1 at e+2: `siso_start`=1, `rd_en`=1 and `rd_addr`=0 in the cycle after e+2.
- `siso_start` and the first `rd_en` coincide.
- `rd_en` is continuous, with no gaps; the last address K+2 is presented K+2 cycles after the first.
- When `siso_ready`=0, START waits indefinitely; `rd_en` stays 0.
- Minimum gap between the end of FEED and the next `siso_start` is 3 cycles: WAIT_EXT, NEXT, START.
- `done` follows the edge at which the final K-th `ext_valid` is counted by 3 cycles: WAIT_EXT, NEXT, DONE.
- `ready` rises the cycle after `done`.

## Test plan
- K=40, n_iter=1, `siso_ready`=1, 40 `ext_valid` per half:
  - 2 `siso_start` pulses;
  - each followed by 43 `rd_en` cycles with `rd_addr` 0..42;
  - `rd_interleaved` 0 then 1;
  - then `done`, with `iter`=1.
- K=41 and K=520:
  - `err` pulse each time, no `siso_start`;
  - `ready` returns 1 two cycles after `valid_blklen`.
- K=6144, n_iter=2:
  - 4 half-iterations, last `rd_addr`=6146;
  - `iter` steps 0→1→2;
  - `done` once.
- n_iter=0 gives 1 iteration. n_iter=12 gives 8 iterations, with `iter` ending at 8.
- `siso_ready` held 0 for 10 cycles in START: no `rd_en` and no `siso_start` until it rises. A `valid_blklen` presented meanwhile is ignored.
- `abort` at `rd_addr`=17 during FEED: next cycle `rd_en`=0, `ready`=1, no `done`.
- `rst` low mid-WAIT_EXT: outputs are immediately at reset values, and a fresh K=512 request then completes normally.
